// File: rtl/sort_seq_ctrl_if.sv
// Valid/ready bundle carrying four p_nbits elements; master sources the data,
// slave returns ready.
interface sort_seq_ctrl_if #(
  parameter int p_nbits = 8
);
  logic                          val;
  logic                          rdy;
  logic [3:0][p_nbits-1:0]       data;

  modport master (output val, output data, input  rdy);
  modport slave  (input  val, input  data, output rdy);
endinterface

// File: rtl/sort_seq_ctrl.sv
// Iterative four-element ascending sorter: one shared min/max unit performs a
// six-step bubble network, one compare-and-swap per cycle.
module sort_seq_ctrl #(
  parameter int p_nbits = 8
) (
  input  logic              clk,
  input  logic              reset,
  sort_seq_ctrl_if.slave    in_if,
  sort_seq_ctrl_if.master   out_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [p_nbits-1:0] r [4];
  logic [2:0]         step;

  logic [1:0]         idx_lo, idx_hi;
  logic [p_nbits-1:0] op_a, op_b, v_min, v_max;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: a default assignment before the case keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_if.val) state_nxt = SORT;
      SORT:    if (step == 3'd5) state_nxt = DONE;
      DONE:    if (out_if.rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs depend on state alone, never on in_val/out_rdy.
  always_comb begin
    in_if.rdy  = 1'b0;
    out_if.val = 1'b0;
    case (state)
      IDLE:    in_if.rdy  = 1'b1;
      DONE:    out_if.val = 1'b1;
      default: ;
    endcase
  end

  // Bubble schedule: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1).
  always_comb begin
    idx_lo = 2'd0;
    idx_hi = 2'd1;
    case (step)
      3'd1, 3'd4: begin idx_lo = 2'd1; idx_hi = 2'd2; end
      3'd2:       begin idx_lo = 2'd2; idx_hi = 2'd3; end
      default:    begin idx_lo = 2'd0; idx_hi = 2'd1; end
    endcase
  end

  // The single min/max unit; ties pass the value through on both sides.
  always_comb begin
    op_a  = r[idx_lo];
    op_b  = r[idx_hi];
    v_min = (op_b < op_a) ? op_b : op_a;
    v_max = (op_b < op_a) ? op_a : op_b;
  end

  // NOTE: the element registers are reset explicitly because out0..out3 must
  // read zero while reset is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) r[k] <= '0;
      step <= 3'd0;
    end else begin
      case (state)
        IDLE: if (in_if.val) begin
          for (int k = 0; k < 4; k++) r[k] <= in_if.data[k];
          step <= 3'd0;
        end
        SORT: begin
          r[idx_lo] <= v_min;
          r[idx_hi] <= v_max;
          step      <= step + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) out_if.data[k] = r[k];
  end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Scoreboard bench for sort_seq_ctrl: the driver queues expected bundles on
// acceptance, a negedge monitor pops and compares on each output handshake.
module tb_sort_seq_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sort_seq_ctrl_if #(.p_nbits(8)) in_if  ();
  sort_seq_ctrl_if #(.p_nbits(8)) out_if ();

  sort_seq_ctrl #(.p_nbits(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .in_if  (in_if),
    .out_if (out_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_out = 0;
  int n_sent = 0;
  logic [31:0] sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Packs out0..out3 into the interface bus layout (element 0 in the low byte).
  function automatic logic [31:0] pk(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Rank-counting reference sort, independent of the bubble schedule.
  function automatic logic [31:0] ref_sort(input logic [31:0] v);
    logic [7:0] e [4];
    logic [7:0] o [4];
    for (int i = 0; i < 4; i++) e[i] = v[8*i +: 8];
    for (int i = 0; i < 4; i++) begin
      int rank = 0;
      for (int j = 0; j < 4; j++)
        if (e[j] < e[i] || (e[j] == e[i] && j < i)) rank++;
      o[rank] = e[i];
    end
    return {o[3], o[2], o[1], o[0]};
  endfunction

  always @(negedge clk) begin
    if (!reset && out_if.val && out_if.rdy) begin
      if (sb.size() == 0) check("unexpected_out", 32'd1, 32'd0);
      else check("out_bundle", out_if.data, sb.pop_front());
      n_out++;
    end
  end

  task automatic send(input logic [31:0] v, input logic [31:0] exp);
    int n = 0;
    @(posedge clk); #1;
    in_if.data = v;
    in_if.val  = 1'b1;
    @(negedge clk);
    while (!in_if.rdy && n < 50) begin @(negedge clk); n++; end
    if (!in_if.rdy) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_if.val = 1'b0;
    end else begin
      sb.push_back(exp);
      n_sent++;
      @(posedge clk); #1;
      in_if.val  = 1'b0;
      in_if.data = 32'hA5A5A5A5;
      acc_cyc = cyc;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
  endtask

  logic rand_on;

  initial begin
    int lows, lat, n;
    logic [31:0] v;
    in_if.val   = 1'b0;
    in_if.data  = '0;
    out_if.rdy  = 1'b1;
    rand_on     = 1'b0;

    #1;
    check("rst_in_rdy",  in_if.rdy,   32'd1);
    check("rst_out_val", out_if.val,  32'd0);
    check("rst_out",     out_if.data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Reverse order: latency and in_rdy-low window.
    send(pk(4, 3, 2, 1), pk(1, 2, 3, 4));
    lows = 0; lat = -1; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (out_if.val && lat < 0) lat = cyc - acc_cyc;
      if (!in_if.rdy) lows++;
    end while (!in_if.rdy && n < 30);
    check("latency",    lat,  32'd6);
    check("in_rdy_low", lows, 32'd7);

    send(pk(8'hFF, 8'h00, 8'h80, 8'h7F), pk(8'h00, 8'h7F, 8'h80, 8'hFF));
    send(pk(1, 2, 3, 4), pk(1, 2, 3, 4));
    send(pk(5, 5, 0, 5), pk(0, 5, 5, 5));
    send(pk(9, 9, 9, 9), pk(9, 9, 9, 9));
    drain();

    // Backpressure: outputs hold, in_val ignored while DONE.
    out_if.rdy = 1'b0;
    send(pk(7, 1, 3, 2), pk(1, 2, 3, 7));
    n = 0;
    do begin @(negedge clk); n++; end while (!out_if.val && n < 20);
    check("bp_val_rise", out_if.val, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_if.val  = 1'b1;
      in_if.data = pk(8'h11, 8'h22, 8'h33, 8'h44);
      @(negedge clk);
      check("bp_val",    out_if.val,  32'd1);
      check("bp_data",   out_if.data, pk(1, 2, 3, 7));
      check("bp_in_rdy", in_if.rdy,   32'd0);
    end
    @(posedge clk); #1;
    in_if.val  = 1'b0;
    out_if.rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_rdy",  in_if.rdy,  32'd1);
    check("bp_release_out_val", out_if.val, 32'd0);
    check("bp_no_dup", sb.size(), 32'd0);

    // Reset during step 3 discards the bundle.
    send(pk(9, 8, 7, 6), pk(6, 7, 8, 9));
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_in_rdy",  in_if.rdy,   32'd1);
    check("abort_out_val", out_if.val,  32'd0);
    check("abort_out",     out_if.data, 32'd0);
    void'(sb.pop_back());
    @(negedge clk) reset = 1'b0;
    send(pk(2, 1, 4, 3), pk(1, 2, 3, 4));
    drain();

    // Random bundles with random in_val gaps and out_rdy stalls.
    n_out = 0;
    rand_on = 1'b1;
    fork
      begin
        for (int b = 0; b < 100; b++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          v = $urandom;
          send(v, ref_sort(v));
        end
        drain();
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_if.rdy = ($urandom_range(0, 2) != 0);
        end
        out_if.rdy = 1'b1;
      end
    join
    check("rand_count", n_out, 32'd100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
